// File: rtl/status_stack_unit.sv
// Micro/machine status registers with a save stack, invertible condition test and carry-in mux.
// State updates one cycle after commands; ct is optionally registered; no backpressure.
module status_stack_unit #(
  parameter int DEPTH  = 4,
  parameter int CT_REG = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   iflags,
  input  logic [3:0]                   yflags,
  input  logic [2:0]                   ucmd,
  input  logic [2:0]                   mcmd,
  input  logic [3:0]                   men,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clr,
  input  logic [3:0]                   cond,
  input  logic [1:0]                   csrc,
  input  logic [1:0]                   cin_sel,
  input  logic                         cin_msr,
  input  logic                         cin_inv,
  input  logic                         cx,
  output logic [3:0]                   usr,
  output logic [3:0]                   msr,
  output logic                         ct,
  output logic                         co,
  output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
  output logic                         full,
  output logic                         empty,
  output logic                         stk_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    usrQ, msrQ, usrD, msrD, mLoad, srcFlags;
  logic [CW-1:0] depthQ, depthD;
  logic          errQ, errD, ctQ, ctComb, baseB;
  logic          isFull, isEmpty, doPush, doPop, errSet;
  logic [7:0]    stackMem [DEPTH];
  logic [7:0]    topEntry;
  logic [AW-1:0] wrIdx, rdIdx;

  assign isFull   = (depthQ == CW'(DEPTH));
  assign isEmpty  = (depthQ == '0);
  assign wrIdx    = AW'(depthQ);
  assign rdIdx    = AW'(depthQ - CW'(1));
  assign topEntry = stackMem[rdIdx];

  always_comb begin
    doPush = push & ~pop;
    doPop  = pop & ~push;
    errSet = (doPush & isFull) | (doPop & isEmpty);

    case (ucmd)
      3'd1:    usrD = iflags;
      3'd2:    usrD = {iflags[3:2], ~iflags[1], iflags[0]};
      3'd3:    usrD = {iflags[3:1], iflags[0] | usrQ[0]};
      3'd4:    usrD = msrQ;
      3'd5:    usrD = 4'hF;
      3'd6:    usrD = 4'h0;
      default: usrD = usrQ;
    endcase

    case (mcmd)
      3'd1:    mLoad = iflags;
      3'd2:    mLoad = {iflags[3:2], ~iflags[1], iflags[0]};
      3'd3:    mLoad = yflags;
      3'd4:    mLoad = usrQ;
      3'd5:    mLoad = usrQ;
      3'd6:    mLoad = ~msrQ;
      3'd7:    mLoad = 4'h0;
      default: mLoad = msrQ;
    endcase
    msrD = (mLoad & men) | (msrQ & ~men);
    // SWAP moves the old MSR into uSR whatever ucmd says
    if (mcmd == 3'd5) usrD = msrQ;

    depthD = depthQ;
    if (doPush && !isFull) depthD = depthQ + CW'(1);
    if (doPop && !isEmpty) begin
      depthD       = depthQ - CW'(1);
      {msrD, usrD} = topEntry;
    end

    errD = errSet | (errQ & ~err_clr);

    case (csrc)
      2'd1:    srcFlags = msrQ;
      2'd2:    srcFlags = iflags;
      default: srcFlags = usrQ;
    endcase
    case (cond[3:1])
      3'd0:    baseB = (srcFlags[2] ^ srcFlags[0]) | srcFlags[3];
      3'd1:    baseB = srcFlags[2] ^ srcFlags[0];
      3'd2:    baseB = srcFlags[3];
      3'd3:    baseB = srcFlags[0];
      3'd4:    baseB = srcFlags[1] | srcFlags[3];
      3'd5:    baseB = srcFlags[1];
      3'd6:    baseB = srcFlags[2];
      default: baseB = 1'b1;
    endcase
    ctComb = baseB ^ cond[0];

    case (cin_sel)
      2'd0:    co = 1'b0;
      2'd1:    co = 1'b1;
      2'd2:    co = cx;
      default: co = (cin_msr ? msrQ[1] : usrQ[1]) ^ cin_inv;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      usrQ   <= '0;
      msrQ   <= '0;
      depthQ <= '0;
      errQ   <= 1'b0;
      ctQ    <= 1'b0;
    end else begin
      usrQ   <= usrD;
      msrQ   <= msrD;
      depthQ <= depthD;
      errQ   <= errD;
      ctQ    <= ctComb;
    end
  end

  // Saves the pre-update registers; contents need no reset
  always_ff @(posedge clk) begin
    if (doPush && !isFull) stackMem[wrIdx] <= {msrQ, usrQ};
  end

  assign usr       = usrQ;
  assign msr       = msrQ;
  assign ct        = (CT_REG != 0) ? ctQ : ctComb;
  assign depth_cnt = depthQ;
  assign full      = isFull;
  assign empty     = isEmpty;
  assign stk_err   = errQ;
endmodule

// File: tb/tb_status_stack_unit.sv
// Scoreboard bench for status_stack_unit: stimulus queues expected values, a negedge monitor checks them.
module tb_status_stack_unit;
  localparam int K_USR = 0, K_MSR = 1, K_CT = 2, K_CO = 3, K_DEPTH = 4;
  localparam int K_FULL = 5, K_EMPTY = 6, K_ERR = 7, K_CTR = 8;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] val;
    string      name;
  } expT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, push, pop, err_clr, cin_msr, cin_inv, cx;
  logic [3:0] iflags, yflags, men, cond;
  logic [2:0] ucmd, mcmd;
  logic [1:0] csrc, cin_sel;

  logic [3:0] usr, msr, usrR, msrR;
  logic       ct, co, full, empty, stk_err;
  logic       ctR, coR, fullR, emptyR, errR;
  logic [2:0] depth_cnt, depthR;

  status_stack_unit #(.DEPTH(4), .CT_REG(0)) dut (
    .clk(clk), .reset(reset), .iflags(iflags), .yflags(yflags), .ucmd(ucmd), .mcmd(mcmd),
    .men(men), .push(push), .pop(pop), .err_clr(err_clr), .cond(cond), .csrc(csrc),
    .cin_sel(cin_sel), .cin_msr(cin_msr), .cin_inv(cin_inv), .cx(cx),
    .usr(usr), .msr(msr), .ct(ct), .co(co), .depth_cnt(depth_cnt), .full(full),
    .empty(empty), .stk_err(stk_err)
  );

  status_stack_unit #(.DEPTH(4), .CT_REG(1)) dutR (
    .clk(clk), .reset(reset), .iflags(iflags), .yflags(yflags), .ucmd(ucmd), .mcmd(mcmd),
    .men(men), .push(push), .pop(pop), .err_clr(err_clr), .cond(cond), .csrc(csrc),
    .cin_sel(cin_sel), .cin_msr(cin_msr), .cin_inv(cin_inv), .cx(cx),
    .usr(usrR), .msr(msrR), .ct(ctR), .co(coR), .depth_cnt(depthR), .full(fullR),
    .empty(emptyR), .stk_err(errR)
  );

  int  cycle = 0;
  int  nChecks = 0;
  int  nFail = 0;
  expT q[$];

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [7:0] actual(int kind);
    case (kind)
      K_USR:   return {4'b0, usr};
      K_MSR:   return {4'b0, msr};
      K_CT:    return {7'b0, ct};
      K_CO:    return {7'b0, co};
      K_DEPTH: return {5'b0, depth_cnt};
      K_FULL:  return {7'b0, full};
      K_EMPTY: return {7'b0, empty};
      K_ERR:   return {7'b0, stk_err};
      K_CTR:   return {7'b0, ctR};
      default: return 8'hxx;
    endcase
  endfunction

  // d=0: check at the coming negedge (current state, current inputs); d=1: after the next edge
  function automatic void chk(int kind, int val, int d, string name);
    expT e;
    e.cyc  = cycle + d;
    e.kind = kind;
    e.val  = 8'(val);
    e.name = name;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    int i;
    logic [7:0] act;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc <= cycle) begin
        act = actual(q[i].kind);
        nChecks++;
        if (act !== q[i].val) begin
          nFail++;
          $display("FAIL %s: got %0h expected %0h (cycle %0d)", q[i].name, act, q[i].val, cycle);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ucmd = 3'd0; mcmd = 3'd0; men = 4'hF;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; idle();
    iflags = 4'h0; yflags = 4'h0; cond = 4'h0; csrc = 2'd0;
    cin_sel = 2'd0; cin_msr = 1'b0; cin_inv = 1'b0; cx = 1'b0;
    tick(); tick();
    chk(K_USR, 0, 0, "rst_usr"); chk(K_MSR, 0, 0, "rst_msr"); chk(K_DEPTH, 0, 0, "rst_depth");
    chk(K_EMPTY, 1, 0, "rst_empty"); chk(K_FULL, 0, 0, "rst_full"); chk(K_ERR, 0, 0, "rst_err");
    chk(K_CTR, 0, 0, "rst_ctr"); chk(K_CT, 0, 0, "rst_ct"); chk(K_CO, 0, 0, "rst_co");
    reset = 1'b0;
    tick();

    // uSR commands
    idle(); ucmd = 3'd1; iflags = 4'hA; chk(K_USR, 4'hA, 1, "u_load"); tick();
    idle(); ucmd = 3'd3; iflags = 4'h0; chk(K_USR, 4'h0, 1, "u_retv"); tick();
    idle(); ucmd = 3'd1; iflags = 4'h1; chk(K_USR, 4'h1, 1, "u_load_ovr"); tick();
    idle(); ucmd = 3'd3; iflags = 4'h0; chk(K_USR, 4'h1, 1, "u_retv_keep"); tick();
    idle(); ucmd = 3'd2; iflags = 4'h0; chk(K_USR, 4'h2, 1, "u_invc"); tick();

    // MSR commands, masking, swap and exchange
    idle(); mcmd = 3'd3; yflags = 4'hF; men = 4'b0101; ucmd = 3'd1; iflags = 4'h3;
    chk(K_MSR, 4'h5, 1, "m_load_y_masked"); chk(K_USR, 4'h3, 1, "u_load3"); tick();
    idle(); mcmd = 3'd5; ucmd = 3'd6;
    chk(K_MSR, 4'h3, 1, "swap_msr"); chk(K_USR, 4'h5, 1, "swap_usr"); tick();
    idle(); ucmd = 3'd4; mcmd = 3'd4;
    chk(K_USR, 4'h3, 1, "xchg_usr"); chk(K_MSR, 4'h5, 1, "xchg_msr"); tick();
    idle(); mcmd = 3'd6; men = 4'b1000; chk(K_MSR, 4'hD, 1, "m_invert_masked"); tick();

    // Fill the stack
    idle(); push = 1'b1; ucmd = 3'd1; iflags = 4'h1;
    chk(K_DEPTH, 1, 1, "push1_depth"); chk(K_EMPTY, 0, 1, "push1_empty"); chk(K_USR, 1, 1, "push1_usr"); tick();
    idle(); push = 1'b1; ucmd = 3'd1; iflags = 4'h2; chk(K_DEPTH, 2, 1, "push2_depth"); tick();
    idle(); push = 1'b1; ucmd = 3'd1; iflags = 4'h4; mcmd = 3'd7; chk(K_MSR, 0, 1, "push3_msr"); tick();
    idle(); push = 1'b1; ucmd = 3'd1; iflags = 4'h8;
    chk(K_DEPTH, 4, 1, "push4_depth"); chk(K_FULL, 1, 1, "push4_full"); chk(K_ERR, 0, 1, "push4_err");
    chk(K_USR, 4'h8, 1, "push4_usr"); tick();
    idle(); push = 1'b1;
    chk(K_ERR, 1, 1, "overflow_err"); chk(K_DEPTH, 4, 1, "overflow_depth"); chk(K_USR, 4'h8, 1, "overflow_usr"); tick();

    // Drain in LIFO order; pop overrides ucmd/mcmd
    idle(); pop = 1'b1; ucmd = 3'd5; mcmd = 3'd7;
    chk(K_USR, 4'h4, 1, "pop1_usr"); chk(K_MSR, 4'h0, 1, "pop1_msr"); chk(K_DEPTH, 3, 1, "pop1_depth");
    chk(K_FULL, 0, 1, "pop1_full"); tick();
    idle(); pop = 1'b1; ucmd = 3'd5; mcmd = 3'd7;
    chk(K_USR, 4'h2, 1, "pop2_usr"); chk(K_MSR, 4'hD, 1, "pop2_msr"); chk(K_DEPTH, 2, 1, "pop2_depth"); tick();
    idle(); pop = 1'b1; ucmd = 3'd5; mcmd = 3'd7;
    chk(K_USR, 4'h1, 1, "pop3_usr"); chk(K_MSR, 4'hD, 1, "pop3_msr"); tick();
    idle(); pop = 1'b1; ucmd = 3'd5; mcmd = 3'd7;
    chk(K_USR, 4'h3, 1, "pop4_usr"); chk(K_MSR, 4'hD, 1, "pop4_msr"); chk(K_DEPTH, 0, 1, "pop4_depth");
    chk(K_EMPTY, 1, 1, "pop4_empty"); chk(K_ERR, 1, 1, "pop4_err_sticky"); tick();
    idle(); pop = 1'b1; ucmd = 3'd6; err_clr = 1'b1;
    chk(K_USR, 4'h0, 1, "underflow_usr"); chk(K_MSR, 4'hD, 1, "underflow_msr");
    chk(K_ERR, 1, 1, "underflow_set_wins"); chk(K_DEPTH, 0, 1, "underflow_depth"); tick();
    idle(); err_clr = 1'b1; chk(K_ERR, 0, 1, "err_clr"); tick();

    // Simultaneous push and pop is a stack no-op
    idle(); push = 1'b1; chk(K_DEPTH, 1, 1, "pa_depth"); tick();
    idle(); push = 1'b1; ucmd = 3'd5; chk(K_USR, 4'hF, 1, "pb_usr"); tick();
    idle(); push = 1'b1; pop = 1'b1; ucmd = 3'd6;
    chk(K_DEPTH, 2, 1, "pp_depth"); chk(K_USR, 4'h0, 1, "pp_usr"); chk(K_ERR, 0, 1, "pp_err"); tick();

    // Condition test
    idle(); mcmd = 3'd3; yflags = 4'b0100; chk(K_MSR, 4'h4, 1, "m_load_n"); tick();
    idle(); csrc = 2'd1; cond = 4'h0;
    chk(K_CT, 1, 0, "ct_c0"); chk(K_CTR, 0, 0, "ctr_c0_old"); chk(K_CTR, 1, 1, "ctr_c0_new"); tick();
    cond = 4'h1; chk(K_CT, 0, 0, "ct_c1"); chk(K_CTR, 1, 0, "ctr_c1_old"); chk(K_CTR, 0, 1, "ctr_c1_new"); tick();
    cond = 4'hE; chk(K_CT, 1, 0, "ct_cE"); chk(K_CTR, 0, 0, "ctr_cE_old"); chk(K_CTR, 1, 1, "ctr_cE_new"); tick();
    cond = 4'hF; chk(K_CT, 0, 0, "ct_cF"); tick();
    cond = 4'hC; chk(K_CT, 1, 0, "ct_msr_n"); tick();
    cond = 4'h6; chk(K_CT, 0, 0, "ct_msr_v"); tick();
    csrc = 2'd2; cond = 4'h4; iflags = 4'b1000; chk(K_CT, 1, 0, "ct_i_z"); tick();
    csrc = 2'd2; cond = 4'h8; iflags = 4'b0010; chk(K_CT, 1, 0, "ct_i_cz"); tick();
    csrc = 2'd0; cond = 4'hA; chk(K_CT, 0, 0, "ct_u_c"); tick();

    // Carry-in mux
    idle(); ucmd = 3'd1; iflags = 4'b0010; chk(K_USR, 4'h2, 1, "u_set_c"); tick();
    idle(); cin_sel = 2'd3; cin_msr = 1'b0; cin_inv = 1'b1; chk(K_CO, 0, 0, "co_uc_inv"); tick();
    cin_inv = 1'b0; chk(K_CO, 1, 0, "co_uc"); tick();
    cin_msr = 1'b1; chk(K_CO, 0, 0, "co_mc"); tick();
    cin_sel = 2'd2; cx = 1'b1; chk(K_CO, 1, 0, "co_cx1"); tick();
    cx = 1'b0; chk(K_CO, 0, 0, "co_cx0"); tick();
    cin_sel = 2'd1; chk(K_CO, 1, 0, "co_one"); tick();
    cin_sel = 2'd0; chk(K_CO, 0, 0, "co_zero"); tick();

    // Reset overrides a push in the same cycle
    idle(); push = 1'b1; reset = 1'b1; cond = 4'hE; csrc = 2'd0;
    chk(K_DEPTH, 0, 1, "rst_push_depth"); chk(K_EMPTY, 1, 1, "rst_push_empty");
    chk(K_CTR, 0, 1, "rst_push_ctr"); chk(K_USR, 0, 1, "rst_push_usr"); tick();
    idle(); reset = 1'b0;
    tick(); tick(); tick();

    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
      nFail += q.size();
      nChecks += q.size();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
